// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared FSM encoding and default timing for the button conditioner
// Contents:
//   btn_state_e             - conditioner FSM states
//   DEFAULT_DEBOUNCE_CYCLES - stable cycles needed to accept a level change (10 ms at 100 MHz)
//   DEFAULT_HOLD_CYCLES     - pressed cycles that qualify a long press (1 s at 100 MHz)
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } btn_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_HOLD_CYCLES     = 100000000;

endpackage

// File: rtl/btn_conditioner_sync2.sv
// rtl/btn_conditioner_sync2.sv - two-flop synchronizer for an asynchronous input
// Ports:
//   clk - sampling clock
//   rst - asynchronous active-low reset, clears both flops
//   d   - asynchronous input
//   q   - synchronized output, lags d by two clk cycles
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounced button level with press/release/long-press strobes
// Macro BTN_LONG_PRESS_EN compiles in the hold counter and long_pulse; without it
// long_pulse is tied low and HOLD_CYCLES has no effect.
// Ports:
//   clk           - master clock
//   rst           - asynchronous active-low reset
//   btn_raw       - asynchronous mechanical button, active-high
//   btn_level     - debounced button level
//   press_pulse   - one-cycle strobe on an accepted press
//   release_pulse - one-cycle strobe on an accepted release
//   long_pulse    - one-cycle strobe once a press has been held HOLD_CYCLES cycles
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  // The cycle in which IDLE/PRESSED first sees the new level is the first stable
  // cycle, so the debounce state only has to witness DEBOUNCE_CYCLES-1 more.
  localparam logic [DW-1:0] DB_LAST   = DW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam bit            DB_SINGLE = (DEBOUNCE_CYCLES <= 1);

  logic          btn_sync;
  btn_state_e    state, state_nxt;
  logic [DW-1:0] db_cnt, db_cnt_nxt;
  logic          press_nxt, release_nxt;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      db_cnt        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    db_cnt_nxt  = db_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_sync) begin
          db_cnt_nxt = '0;
          if (DB_SINGLE) begin
            state_nxt = PRESSED;
            press_nxt = 1'b1;
          end else begin
            state_nxt = PRESS_DB;
          end
        end
      end
      PRESS_DB: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
        end else if (db_cnt >= DB_LAST) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          db_cnt_nxt = '0;
          if (DB_SINGLE) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else begin
            state_nxt = RELEASE_DB;
          end
        end
      end
      RELEASE_DB: begin
        if (btn_sync) begin
          state_nxt = PRESSED;
        end else if (db_cnt >= DB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign btn_level = (state == PRESSED) || (state == RELEASE_DB);

`ifdef BTN_LONG_PRESS_EN
  localparam int            HW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [HW-1:0] hold_cnt;

  // The count survives a release glitch (RELEASE_DB back to PRESSED) and restarts
  // only on a newly accepted press. Leaving to IDLE clears it, which also keeps
  // long_pulse from landing on the same cycle as release_pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (press_nxt || !(state_nxt inside {PRESSED, RELEASE_DB})) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt   <= hold_cnt + 1'b1;
        long_pulse <= (hold_cnt == HOLD_MAX - 1'b1);
      end
    end
  end
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^HOLD_CYCLES;
  assign long_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner against a run-length reference model
module tb_btn_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 10;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the button value seen two edges ago is compared with the
  // accepted level; a run of DB consecutive differing samples flips the level.
  logic m_d1, m_d2, m_level;
  int   m_run, m_hold;
  logic exp_press, exp_release, exp_long;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_level = 0; m_run = 0; m_hold = 0;
    exp_press = 0; exp_release = 0; exp_long = 0;
  endtask

  task automatic model_edge(input logic r);
    logic s;
    s = m_d2;
    m_d2 = m_d1;
    m_d1 = r;
    exp_press = 0; exp_release = 0; exp_long = 0;
    if (s != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = s;
        m_run   = 0;
        if (s) begin
          exp_press = 1;
          m_hold    = 0;
        end else begin
          exp_release = 1;
        end
      end
    end else begin
      m_run = 0;
    end
    if (m_level && !exp_press && m_hold < HOLD) begin
      m_hold++;
      if (m_hold == HOLD && LONG_EN) exp_long = 1;
    end
  endtask

  function automatic logic [3:0] exp_vec();
    return {m_level, exp_press, exp_release, exp_long};
  endfunction

  // Drive btn_raw for one cycle, advance the model at the edge, return at the negedge.
  task automatic tick(input logic r);
    btn_raw = r;
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge(r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0;
    btn_raw = 1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: outputs=%b expected 0000", i,
                 {btn_level, press_pulse, release_pulse, long_pulse});
      end
    end
    btn_raw = 0;
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: outputs=%b expected 0000", i,
                 {btn_level, press_pulse, release_pulse, long_pulse});
      end
    end
  endtask

  task automatic test_clean_press();
    int press_n = 0, press_at = -1, rel_n = 0, rel_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1);
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== exp_vec()) begin
        n_err++;
        $display("FAIL clean_model cycle %0d: got %b expected %b", i,
                 {btn_level, press_pulse, release_pulse, long_pulse}, exp_vec());
      end
      if (press_pulse) begin press_n++; press_at = i; end
      if (i >= 6) begin
        n_checks++;
        if (btn_level !== 1'b1) begin
          n_err++;
          $display("FAIL clean_level cycle %0d: got %b expected 1", i, btn_level);
        end
      end
    end
    n_checks++;
    if (press_n != 1 || press_at != 6) begin
      n_err++;
      $display("FAIL clean_press_timing: count=%0d at=%0d expected count=1 at=6", press_n, press_at);
    end
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0);
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== exp_vec()) begin
        n_err++;
        $display("FAIL clean_release_model cycle %0d: got %b expected %b", i,
                 {btn_level, press_pulse, release_pulse, long_pulse}, exp_vec());
      end
      if (release_pulse) begin rel_n++; rel_at = i; end
    end
    n_checks++;
    if (rel_n != 1 || rel_at != 6) begin
      n_err++;
      $display("FAIL clean_release_timing: count=%0d at=%0d expected count=1 at=6", rel_n, rel_at);
    end
  endtask

  task automatic test_bounce();
    int press_n = 0, press_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick((i <= 4) ? logic'(i % 2) : 1'b1);
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== exp_vec()) begin
        n_err++;
        $display("FAIL bounce_model cycle %0d: got %b expected %b", i,
                 {btn_level, press_pulse, release_pulse, long_pulse}, exp_vec());
      end
      if (press_pulse) begin press_n++; press_at = i; end
    end
    // final rise is driven in cycle 5, so the press lands 6 cycles later, in cycle 10
    n_checks++;
    if (press_n != 1 || press_at != 10) begin
      n_err++;
      $display("FAIL bounce_press: count=%0d at=%0d expected count=1 at=10", press_n, press_at);
    end
    for (int i = 1; i <= 12; i++) tick(1'b0);
  endtask

  task automatic test_release_glitch();
    int press_n = 0, rel_n = 0, long_n = 0, long_at = -1;
    for (int i = 1; i <= 22; i++) begin
      tick((i == 11 || i == 12) ? 1'b0 : 1'b1);
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== exp_vec()) begin
        n_err++;
        $display("FAIL glitch_model cycle %0d: got %b expected %b", i,
                 {btn_level, press_pulse, release_pulse, long_pulse}, exp_vec());
      end
      if (press_pulse) press_n++;
      if (release_pulse) rel_n++;
      if (long_pulse) begin long_n++; long_at = i; end
      if (i >= 6) begin
        n_checks++;
        if (btn_level !== 1'b1) begin
          n_err++;
          $display("FAIL glitch_level cycle %0d: got %b expected 1", i, btn_level);
        end
      end
    end
    n_checks++;
    if (press_n != 1 || rel_n != 0) begin
      n_err++;
      $display("FAIL glitch_pulses: press=%0d release=%0d expected press=1 release=0", press_n, rel_n);
    end
    // the hold count keeps running through the glitch: long still at press+10
    n_checks++;
    if (long_n != (LONG_EN ? 1 : 0) || (LONG_EN && long_at != 16)) begin
      n_err++;
      $display("FAIL glitch_long: count=%0d at=%0d expected count=%0d at=16", long_n, long_at, LONG_EN ? 1 : 0);
    end
    for (int i = 1; i <= 12; i++) tick(1'b0);
  endtask

  task automatic test_long_press();
    int press_at = -1, long_n = 0, long_at = -1, rel_n = 0, rel_at = -1;
    for (int i = 1; i <= 30; i++) begin
      tick(1'b1);
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== exp_vec()) begin
        n_err++;
        $display("FAIL long_model cycle %0d: got %b expected %b", i,
                 {btn_level, press_pulse, release_pulse, long_pulse}, exp_vec());
      end
      if (press_pulse) press_at = i;
      if (long_pulse) begin long_n++; long_at = i; end
    end
    n_checks++;
    if (press_at != 6) begin
      n_err++;
      $display("FAIL long_press_at: got %0d expected 6", press_at);
    end
    n_checks++;
    if (LONG_EN ? (long_n != 1 || long_at != press_at + HOLD) : (long_n != 0)) begin
      n_err++;
      $display("FAIL long_pulse: count=%0d at=%0d expected count=%0d at=%0d",
               long_n, long_at, LONG_EN ? 1 : 0, press_at + HOLD);
    end
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0);
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== exp_vec()) begin
        n_err++;
        $display("FAIL long_release_model cycle %0d: got %b expected %b", i,
                 {btn_level, press_pulse, release_pulse, long_pulse}, exp_vec());
      end
      if (release_pulse) begin rel_n++; rel_at = i; end
    end
    n_checks++;
    if (rel_n != 1 || rel_at != 6) begin
      n_err++;
      $display("FAIL long_release: count=%0d at=%0d expected count=1 at=6", rel_n, rel_at);
    end
  endtask

  task automatic test_reset_mid_press();
    int press_n = 0, press_at = -1, rel_n = 0;
    for (int i = 1; i <= 8; i++) tick(1'b1);
    n_checks++;
    if (btn_level !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre_level: got %b expected 1", btn_level);
    end
    rst = 0;
    model_reset();
    #1;
    n_checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_immediate: outputs=%b expected 0000",
               {btn_level, press_pulse, release_pulse, long_pulse});
    end
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1);
      if (release_pulse) rel_n++;
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
        n_err++;
        $display("FAIL midreset_held cycle %0d: outputs=%b expected 0000", i,
                 {btn_level, press_pulse, release_pulse, long_pulse});
      end
    end
    rst = 1;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1);
      n_checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== exp_vec()) begin
        n_err++;
        $display("FAIL midreset_model cycle %0d: got %b expected %b", i,
                 {btn_level, press_pulse, release_pulse, long_pulse}, exp_vec());
      end
      if (press_pulse) begin press_n++; press_at = i; end
      if (release_pulse) rel_n++;
    end
    n_checks++;
    if (press_n != 1 || press_at != 6 || rel_n != 0) begin
      n_err++;
      $display("FAIL midreset_after: press=%0d at=%0d release=%0d expected press=1 at=6 release=0",
               press_n, press_at, rel_n);
    end
    for (int i = 1; i <= 12; i++) tick(1'b0);
  endtask

  task automatic test_random();
    logic v = 1'b0;
    int   len;
    int   cyc = 0;
    while (cyc < 500) begin
      v   = ~v;
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        tick(v);
        cyc++;
        n_checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse} !== exp_vec()) begin
          n_err++;
          $display("FAIL random_model cycle %0d: got %b expected %b", cyc,
                   {btn_level, press_pulse, release_pulse, long_pulse}, exp_vec());
        end
        n_checks++;
        if ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse)) > 1) begin
          n_err++;
          $display("FAIL random_exclusive cycle %0d: pulses=%b expected at most one high", cyc,
                   {press_pulse, release_pulse, long_pulse});
        end
      end
    end
  endtask

  initial begin
    rst     = 0;
    btn_raw = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_long_press();
    test_reset_mid_press();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 Parameter HOLD_CYCLES, default 100000000, is the number of pressed cycles after acceptance that qualify a long press (1 s).
REQ-003 Port clk, input, 1 bit, 100 MHz master clock; sole clock.
REQ-004 Port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 Port btn_raw, input, 1 bit, asynchronous mechanical button, active-high.
REQ-006 Port btn_level, output, 1 bit, debounced button level.
REQ-007 Port press_pulse, output, 1 bit, one-cycle strobe on an accepted press; this is the roll trigger.
REQ-008 Port release_pulse, output, 1 bit, one-cycle strobe on an accepted release.
REQ-009 Port long_pulse, output, 1 bit, one-cycle strobe when a press has been held for HOLD_CYCLES.

Function
REQ-010 btn_raw SHALL pass through a two-flop synchronizer; the internal btn_sync lags btn_raw by 2 cycles.
REQ-011 The FSM SHALL have four states: IDLE, PRESS_DB, PRESSED, and RELEASE_DB.
REQ-012 In IDLE with btn_sync=1, the FSM SHALL go to PRESS_DB and clear the debounce counter.
REQ-013 In PRESS_DB with btn_sync=0, the FSM SHALL return to IDLE with no pulse.
REQ-014 In PRESS_DB, once btn_sync has been 1 for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL go to PRESSED and assert press_pulse for exactly that one cycle.
REQ-015 In PRESSED with btn_sync=0, the FSM SHALL go to RELEASE_DB and clear the debounce counter.
REQ-016 In RELEASE_DB with btn_sync=1, the FSM SHALL return to PRESSED without a second press_pulse, and the hold counter SHALL continue counting.
REQ-017 In RELEASE_DB, once btn_sync has been 0 for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL go to IDLE and assert release_pulse for exactly one cycle.
REQ-018 btn_level SHALL be 1 in PRESSED and RELEASE_DB, and 0 in IDLE and PRESS_DB.
REQ-019 The hold counter SHALL clear on entry to PRESSED from PRESS_DB and increment each cycle in PRESSED and RELEASE_DB.
REQ-020 The hold counter SHALL saturate at HOLD_CYCLES and never wrap.
REQ-021 long_pulse SHALL assert for one cycle when the hold counter first reaches HOLD_CYCLES, at most once per accepted press.
REQ-022 press_pulse, release_pulse and long_pulse SHALL never be high in the same cycle.
REQ-023 Counter widths SHALL be $clog2(parameter+1); DEBOUNCE_CYCLES=1 SHALL give press_pulse on the first cycle after btn_sync rises.

Reset
REQ-024 rst=0 SHALL immediately force: the FSM to IDLE, all counters to 0, both synchronizer flops to 0, and all outputs to 0.
REQ-025 Reset asserted mid-press SHALL produce no release_pulse.
REQ-026 After rst deasserts with btn_raw already held high, a press SHALL be accepted normally per REQ-014.

Configuration
REQ-027 Macro BTN_LONG_PRESS_EN SHALL compile in the hold counter and long_pulse logic.
REQ-028 Without BTN_LONG_PRESS_EN, long_pulse SHALL be tied to 0, no hold counter SHALL exist, and HOLD_CYCLES SHALL be ignored.

Structure
REQ-029 Shared package btn_pkg SHALL hold the FSM state encodings and the default DEBOUNCE_CYCLES/HOLD_CYCLES constants.
REQ-030 The two-flop synchronizer SHALL be a sub-module named sync2 with ports clk, rst, d and q.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, BTN_LONG_PRESS_EN defined unless stated)
REQ-031 Clean press: btn_raw 0->1 held for 20 cycles -> press_pulse single cycle at 2+4 cycles after the edge; btn_level=1 from that cycle onward.
REQ-032 Bounce: btn_raw toggles 1,0,1,0 every cycle, then stays 1 -> exactly one press_pulse, 6 cycles after the final rise.
REQ-033 Release glitch: while pressed, btn_raw low for 2 cycles, then high -> no release_pulse, no second press_pulse, btn_level stays 1.
REQ-034 Long press: hold btn_raw 30 cycles -> long_pulse exactly once, 10 cycles after press_pulse; on release, one release_pulse 6 cycles after the falling edge.
REQ-035 Reset mid-press: rst low while in PRESSED -> all outputs 0 within the same cycle; after rst high with btn_raw=1 -> press_pulse after 6 cycles.
REQ-036 Macro off: repeat REQ-034 without BTN_LONG_PRESS_EN -> long_pulse stays 0; press and release timing unchanged.
